// File: rtl/button_toggle_bank_pkg.sv
// Shared types for the push-button toggle bank: per-channel FSM states and
// the encodings of the run-time mode select.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PRESS   = 2'b01,
      HELD    = 2'b11,
      RELEASE = 2'b10
   } btn_state_t;

   localparam logic MODE_TOGGLE    = 1'b0;
   localparam logic MODE_MOMENTARY = 1'b1;

   // True while the button is considered down by the FSM (drives momentary out).
   function automatic logic is_down(input btn_state_t s);
      return (s == PRESS) || (s == HELD);
   endfunction

endpackage

// File: rtl/button_toggle_bank_if.sv
// Button bank bus: raw buttons, mode/clear controls from the user side and
// the per-channel outputs and strobes back to it.
interface button_toggle_bank_if #(
   parameter int N_BTN = 4
) ();
   logic [N_BTN-1:0] btn;
   logic [N_BTN-1:0] mode;
   logic             clear;
   logic [N_BTN-1:0] out;
   logic [N_BTN-1:0] press_pulse;
   logic [N_BTN-1:0] release_pulse;

   modport master (
      output btn, mode, clear,
      input  out, press_pulse, release_pulse
   );

   modport slave (
      input  btn, mode, clear,
      output out, press_pulse, release_pulse
   );
endinterface

// File: rtl/button_toggle_bank_debounce.sv
// One button channel front end: two-flop synchroniser, polarity normalisation
// and a counter debouncer that accepts a level after DEBOUNCE_CYCLES stable cycles.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic stable
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_reg;
   logic          s2_reg;
   logic          stable_reg;
   logic [CW-1:0] count_reg;
   logic          pressed;

   // Synchroniser flops hold the raw level, so they reset to the released raw value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_reg <= ACTIVE_LOW;
         s2_reg <= ACTIVE_LOW;
      end else begin
         s1_reg <= btn;
         s2_reg <= s1_reg;
      end
   end

   assign pressed = s2_reg ^ ACTIVE_LOW;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_reg <= 1'b0;
         count_reg  <= '0;
      end else if (pressed == stable_reg) begin
         count_reg  <= '0;
      end else if (count_reg == LAST) begin
         stable_reg <= pressed;
         count_reg  <= '0;
      end else begin
         count_reg  <= count_reg + 1'b1;
      end
   end

   assign stable = stable_reg;

endmodule

// File: rtl/button_toggle_bank.sv
// Bank of N_BTN debounced push-button channels, each with a press/hold/release
// FSM, a toggle latch and a toggle/momentary output mux selected at run time.
module button_toggle_bank
   import button_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   button_toggle_bank_if.slave bus
);
   logic [N_BTN-1:0] stable;
   logic [N_BTN-1:0] out_vec;
   logic [N_BTN-1:0] press_vec;
   logic [N_BTN-1:0] release_vec;

   generate
      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
         btn_state_t state_reg;
         btn_state_t state_next;
         logic       toggle_reg;
         logic       toggle_next;

         button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
         ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .btn   (bus.btn[gi]),
            .stable(stable[gi])
         );

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_reg  <= IDLE;
               toggle_reg <= 1'b0;
            end else begin
               state_reg  <= state_next;
               toggle_reg <= toggle_next;
            end
         end

         // The latch flips on the edge that enters PRESS so out changes with press_pulse.
         always_comb begin
            state_next  = state_reg;
            toggle_next = toggle_reg;
            unique case (state_reg)
               IDLE: begin
                  if (stable[gi]) begin
                     state_next  = PRESS;
                     toggle_next = ~toggle_reg;
                  end
               end
               PRESS:   state_next = HELD;
               HELD:    if (!stable[gi]) state_next = RELEASE;
               RELEASE: state_next = IDLE;
               default: state_next = IDLE;
            endcase
            if (bus.clear) toggle_next = 1'b0;
         end

         assign out_vec[gi]     = (bus.mode[gi] == MODE_MOMENTARY) ? is_down(state_reg) : toggle_reg;
         assign press_vec[gi]   = (state_reg == PRESS);
         assign release_vec[gi] = (state_reg == RELEASE);
      end
   endgenerate

   assign bus.out           = out_vec;
   assign bus.press_pulse   = press_vec;
   assign bus.release_pulse = release_vec;

endmodule

// File: doc/button_toggle_bank.md
# button_toggle_bank

Parametrised bank of N push-button channels, each with a two-flop synchroniser, a counter debouncer and a per-channel press/hold/release state machine. Every channel produces either a latched toggle output or a momentary (follow-the-button) output, selected per channel at run time, plus one-cycle press and release strobes. The bank sits between the board push-buttons and the user logic, replacing single-button toggle latches.

## Interface
- N_BTN, 4: number of independent channels (1..16)
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to accept a level change (>=1)
- ACTIVE_LOW, 1: 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- btn  in  N_BTN  raw, asynchronous button levels
- mode  in  N_BTN  per channel: 0 = toggle, 1 = momentary
- clear  in  1  synchronous: forces all toggle latches to 0
- out  out  N_BTN  per-channel output (toggle latch or debounced held level, per mode)
- press_pulse  out  N_BTN  one-cycle strobe on accepted press
- release_pulse  out  N_BTN  one-cycle strobe on accepted release

## Operation
- Polarity: pressed = btn ^ ACTIVE_LOW, normalised after the synchroniser.
- Synchroniser: two flops per channel (s1, s2), reset to the released level.
- Debounce: stable register (reset 0 = released) and counter, width $clog2(DEBOUNCE_CYCLES+1), reset 0.
  - s2 == stable: the counter clears to 0.
  - s2 != stable: the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, stable takes s2 and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Per-channel FSM, 2-bit, reset IDLE:
  - IDLE: stable=1 -> PRESS; else stay.
  - PRESS: lasts one cycle. Asserts press_pulse. Toggles the latch. Next state is HELD.
  - HELD: stable=0 -> RELEASE; else stay.
  - RELEASE: lasts one cycle. Asserts release_pulse. Next state is IDLE.
  - Illegal encoding -> IDLE.
- out[i]:
  - mode[i]=0: equals toggle_q[i].
  - mode[i]=1: 1 while the FSM is in PRESS or HELD, else 0.
  - out is a combinational mux of registered state; mode changes take effect in the same cycle.
- clear: on the next edge toggle_q <= 0 for all channels.
  - clear wins over a simultaneous PRESS toggle.
  - press_pulse is still emitted.
  - FSM state is unaffected.
- Channels are fully independent; simultaneous presses on several channels are each handled.

## Timing
- Reset values: out=0, press_pulse=0, release_pulse=0, toggle_q=0, all FSMs IDLE, counters 0, stable=released.
- Press latency: the press level is present before edge 0 and held. s2 is valid after edge 1. stable sets at edge 1+DEBOUNCE_CYCLES. The FSM enters PRESS at edge 2+DEBOUNCE_CYCLES. press_pulse is high for exactly the cycle after that edge.
- Release latency: symmetric, DEBOUNCE_CYCLES+3 edges to the release_pulse cycle.
- A toggle-mode out change appears together with press_pulse.
- Minimum press-to-press period: 2*(DEBOUNCE_CYCLES)+4 cycles. Faster activity is filtered, never queued.
- rst mid-operation: all state clears immediately and asynchronously, with no pulse emitted.
  - A button held through reset deassertion is treated as a new press: press_pulse follows DEBOUNCE_CYCLES+3 edges after reset release.
- The toggle-mode latch keeps its value while the channel is in momentary mode, and reappears when switched back.

## Structure
- Package button_pkg:
  - FSM state localparams IDLE=2'b00, PRESS=2'b01, HELD=2'b11, RELEASE=2'b10.
  - Mode encodings MODE_TOGGLE=0, MODE_MOMENTARY=1.
- Sub-module button_debounce: one channel of synchroniser, polarity and debounce counter. Parameters DEBOUNCE_CYCLES and ACTIVE_LOW. Output stable.
- The top level generates N_BTN instances plus per-channel FSM, toggle latch and output mux.

## Test plan
- Reset, then N_BTN=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, btn[0] driven 0 and held. Expect press_pulse[0] for one cycle after edge 6 and out[0] 0->1. Then release, and expect release_pulse[0] after 7 edges with out[0] staying 1.
- Pulse btn[1] low for 3 cycles (glitch < 4). Expect no pulses and out[1] remains 0.
- Press and release btn[2] twice in toggle mode. Expect out[2] 0->1->0 and two press_pulses.
- mode[3]=1, hold btn[3] for 20 cycles. Expect out[3]=1 from the press_pulse cycle until the release_pulse cycle, and toggle_q[3] still toggled. Switching mode[3]=0 shows out[3]=1.
- Assert clear in the same cycle as a press_pulse on channel 0 with toggle_q[0]=0. Expect out[0]=0 and the press_pulse still seen.
- Assert rst while channel 1 is in HELD. Expect all outputs 0 immediately. Keep btn[1] pressed through reset release and expect press_pulse[1] 7 edges after release.
